// File: rtl/pc_gen_pkg.sv
// Shared core package for the fetch PC generator: FSM state encoding,
// the sequential fetch increment and the default boot address.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pc_gen_state_t;

    localparam logic [63:0] PC_INC           = 64'd4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/pc_gen.sv
// Fetch program-counter generator.
// Holds the registered fetch address, advances it sequentially, and loads
// trap/branch targets, inserting FLUSH_CYCLES bubble cycles after each one.
// Optional feature macro: PC_GEN_MISALIGN_CHK_EN -- when defined, targets with
// nonzero bits[1:0] are force-aligned and misalign_o pulses for one cycle
// together with the pc update; otherwise targets load unmodified and
// misalign_o is tied low.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i,
    input  logic        trap_valid_i,
    input  logic [63:0] trap_pc_i,
    output logic [63:0] pc,
    output logic        fetch_stall,
    output logic        fetch_bubble,
    output logic        misalign_o
);

    // Reload value for the 3-bit bubble counter (legal FLUSH_CYCLES is 1..7).
    localparam logic [2:0] FLUSH_INIT = FLUSH_CYCLES[2:0];

    pc_gen_state_t state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [2:0]    flush_cnt_q, flush_cnt_d;
    logic          take_target;
    logic [63:0]   target_pc;
    logic [63:0]   sel_pc;
`ifdef PC_GEN_MISALIGN_CHK_EN
    logic          misalign_q, misalign_d;
    logic          sel_misalign;
`endif

    // Next-state, next-pc and counter selection; trap beats redirect beats stall.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_cnt_d = flush_cnt_q;
        take_target = 1'b0;
        target_pc   = trap_valid_i ? trap_pc_i : redirect_pc_i;
`ifdef PC_GEN_MISALIGN_CHK_EN
        sel_pc       = {target_pc[63:2], 2'b00};
        sel_misalign = |target_pc[1:0];
        misalign_d   = 1'b0;
`else
        sel_pc       = target_pc;
`endif

        case (state_q)
            // Boot holds the reset address for one cycle; redirects are ignored.
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (trap_valid_i || redirect_valid_i) begin
                    take_target = 1'b1;
                end else if (!stall_i) begin
                    pc_d = pc_q + PC_INC;
                end
            end
            // Bubble cycles ignore stall; a fresh redirect restarts the count.
            FLUSH: begin
                if (trap_valid_i || redirect_valid_i) begin
                    take_target = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (take_target) begin
            pc_d        = sel_pc;
            flush_cnt_d = FLUSH_INIT;
            state_d     = FLUSH;
`ifdef PC_GEN_MISALIGN_CHK_EN
            misalign_d  = sel_misalign;
`endif
        end
    end

    // State, pc and counter registers; reset discards everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef PC_GEN_MISALIGN_CHK_EN
    // Misalignment flag is registered so it lines up with the pc update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    assign pc           = pc_q;
    assign fetch_bubble = trap_valid_i | redirect_valid_i | (state_q != RUN);
    assign fetch_stall  = stall_i & (state_q == RUN) & ~trap_valid_i & ~redirect_valid_i;

endmodule
